// File: rtl/jt51_acc_seq.sv
// jt51_acc_seq -- slot sequencer and frame sample capture for the jt51 accumulator.
//
// A 5-bit slot counter walks the 32 operator slots of a frame. An offset,
// fixed at elaboration time, is added to the counter before decoding, so the
// strobes can be lined up with the operator pipeline delay. The decode feeds
// the accumulator sequencing strobes. Once per frame, when the C1 update is
// complete (decoded slot 24), the accumulated left/right sums are captured
// into a one-deep buffer. A valid/ready handshake hands them to the consumer.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   cen                   clock enable for slot sequencing and capture
//   sync                  realign: slot counter goes to 0 on the next cen
//   xleft, xright         accumulated frame sums (signed 16)
//   m1/m2/c1/c2_enters    operator-group strobes (exactly one high)
//   op31_acc              high on decoded slot 31 only
//   slot, ch              raw slot counter and its low 3 bits
//   sample                one-clk pulse after each frame capture
//   smp_valid/smp_ready   handshake to the sample consumer
//   smp_left/smp_right    held sample, bit-exact copy of xleft/xright
//   overrun, clr_ovr      sticky flag set when an unread sample is overwritten

module jt51_acc_seq #(
    parameter int unsigned SLOT_OFS = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               sync,
    input  logic signed [15:0] xleft,
    input  logic signed [15:0] xright,
    output logic               m1_enters,
    output logic               m2_enters,
    output logic               c1_enters,
    output logic               c2_enters,
    output logic               op31_acc,
    output logic [4:0]         slot,
    output logic [2:0]         ch,
    output logic               sample,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic signed [15:0] smp_left,
    output logic signed [15:0] smp_right,
    output logic               overrun,
    input  logic               clr_ovr
);

    // Offset reduced to 5 bits; the 5-bit add below wraps mod 32 by itself.
    localparam logic [4:0] OFS       = 5'(SLOT_OFS % 32);
    localparam logic [4:0] CAP_SLOT  = 5'd24;
    localparam logic [4:0] LAST_SLOT = 5'd31;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } smp_t;

    logic [4:0] s;
    logic [4:0] d;
    smp_t       held;
    logic       capture;
    logic       xfer;
    logic       ovr_set;

    // Decoded slot, computed from the registered counter with no extra stage.
    assign d = s + OFS;

    assign capture = cen && (d == CAP_SLOT);
    assign xfer    = smp_valid && smp_ready;
    // The overwrite condition: a capture lands while the old sample is still
    // unread and is not being taken on this edge.
    assign ovr_set = capture && smp_valid && !xfer;

    always_comb begin
        m1_enters = 1'b0;
        m2_enters = 1'b0;
        c1_enters = 1'b0;
        c2_enters = 1'b0;
        case (d[4:3])
            2'd0:    m1_enters = 1'b1;
            2'd1:    m2_enters = 1'b1;
            2'd2:    c1_enters = 1'b1;
            default: c2_enters = 1'b1;
        endcase
        op31_acc = (d == LAST_SLOT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            sample    <= 1'b0;
            smp_valid <= 1'b0;
            overrun   <= 1'b0;
            held      <= '0;
        end else begin
            if (cen)
                s <= sync ? 5'd0 : s + 5'd1;

            sample <= capture;

            // A capture wins over a transfer on the same edge. The old value
            // is consumed, the new one is loaded, and valid stays high.
            if (capture)
                smp_valid <= 1'b1;
            else if (xfer)
                smp_valid <= 1'b0;

            if (capture)
                held <= '{left: xleft, right: xright};

            // A set on the same edge as a clear wins.
            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    assign slot      = s;
    assign ch        = s[2:0];
    assign smp_left  = held.left;
    assign smp_right = held.right;

endmodule

// File: tb/tb_jt51_acc_seq.sv
module tb_jt51_acc_seq;

    logic clk;
    logic rst_n, cen, sync, smp_ready, clr_ovr;
    logic signed [15:0] xleft, xright;

    logic m1, m2, c1, c2, op31, sample, smp_valid, overrun;
    logic [4:0] slot;
    logic [2:0] ch;
    logic signed [15:0] smp_left, smp_right;

    logic m1_8, m2_8, c1_8, c2_8, op31_8, sample_8, valid_8, ovr_8;
    logic [4:0] slot_8;
    logic [2:0] ch_8;
    logic signed [15:0] left_8, right_8;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              m_s;
    bit              m_valid, m_sample, m_ovr;
    logic [15:0]     m_left, m_right;

    jt51_acc_seq #(.SLOT_OFS(0)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync),
        .xleft(xleft), .xright(xright),
        .m1_enters(m1), .m2_enters(m2), .c1_enters(c1), .c2_enters(c2),
        .op31_acc(op31), .slot(slot), .ch(ch), .sample(sample),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_left(smp_left), .smp_right(smp_right),
        .overrun(overrun), .clr_ovr(clr_ovr)
    );

    jt51_acc_seq #(.SLOT_OFS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync),
        .xleft(xleft), .xright(xright),
        .m1_enters(m1_8), .m2_enters(m2_8), .c1_enters(c1_8), .c2_enters(c2_8),
        .op31_acc(op31_8), .slot(slot_8), .ch(ch_8), .sample(sample_8),
        .smp_valid(valid_8), .smp_ready(smp_ready),
        .smp_left(left_8), .smp_right(right_8),
        .overrun(ovr_8), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_strobes(int s, int ofs);
        return 4'b0001 << (((s + ofs) % 32) / 8);
    endfunction

    // One clock: advance the model from the inputs applied at this edge, then
    // return 1 time unit after the edge, so outputs can be sampled.
    task automatic step();
        bit cap, xf;
        @(posedge clk);
        cap = cen && (m_s == 24);
        xf  = m_valid && smp_ready;
        if (!rst_n) begin
            m_s = 0; m_valid = 0; m_sample = 0; m_ovr = 0; m_left = 0; m_right = 0;
        end else begin
            m_sample = cap;
            if (cen) m_s = sync ? 0 : (m_s + 1) % 32;
            if (cap && m_valid && !xf) m_ovr = 1;
            else if (clr_ovr)          m_ovr = 0;
            if (cap) begin
                m_left = xleft; m_right = xright; m_valid = 1;
            end else if (xf) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic wait_slot(int target);
        int n;
        n = 0;
        cen = 1;
        while (m_s != target && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (m_s != target) begin
            errors++;
            $display("FAIL wait_slot timeout: model slot %0d, wanted %0d", m_s, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cen = 1; sync = 0; smp_ready = 0; clr_ovr = 0; xleft = 0; xright = 0;
        step(); step();
        checks++;
        if (slot !== 5'd0 || smp_valid !== 1'b0 || sample !== 1'b0 || overrun !== 1'b0 ||
            smp_left !== 16'sd0 || smp_right !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: slot=%0d valid=%b sample=%b ovr=%b l=%h r=%h, want all 0",
                     slot, smp_valid, sample, overrun, smp_left, smp_right);
        end
        checks++;
        if ({c2, c1, m2, m1, op31} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00010", {c2, c1, m2, m1, op31});
        end
        checks++;
        if ({c2_8, c1_8, m2_8, m1_8} !== 4'b0010) begin
            errors++;
            $display("FAIL ofs8_strobes_at_s0: got %b want 0010", {c2_8, c1_8, m2_8, m1_8});
        end
        rst_n = 1;
        step();
        checks++;
        if (slot !== 5'd1) begin
            errors++;
            $display("FAIL first_frame_start: slot=%0d want 1", slot);
        end
    endtask

    task automatic test_free_run();
        bit wrapped;
        wrapped = 0;
        cen = 1; smp_ready = 1;
        for (int i = 0; i < 64; i++) begin
            int prev;
            prev = m_s;
            step();
            if (prev == 31 && m_s == 0) wrapped = 1;
            checks++;
            if (slot !== 5'(m_s) || ch !== 3'(m_s % 8)) begin
                errors++;
                $display("FAIL free_run_slot: slot=%0d ch=%0d want %0d", slot, ch, m_s);
            end
            checks++;
            if ({c2, c1, m2, m1} !== exp_strobes(m_s, 0) || op31 !== (m_s == 31)) begin
                errors++;
                $display("FAIL free_run_strobes: s=%0d got %b op31=%b want %b", m_s,
                         {c2, c1, m2, m1}, op31, exp_strobes(m_s, 0));
            end
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL free_run_wrap: no 31->0 wrap seen");
        end
    endtask

    task automatic test_cen_gated();
        int start;
        start = m_s;
        for (int i = 0; i < 40; i++) begin
            cen  = (i % 4 == 0);
            sync = (i % 4 == 2);
            step();
            checks++;
            if (slot !== 5'(m_s) || {c2, c1, m2, m1} !== exp_strobes(m_s, 0)) begin
                errors++;
                $display("FAIL cen_gated: slot=%0d strobes=%b want %0d", slot, {c2, c1, m2, m1}, m_s);
            end
        end
        sync = 0; cen = 1;
        checks++;
        if (slot !== 5'((start + 10) % 32)) begin
            errors++;
            $display("FAIL cen_gated_advance: slot=%0d want %0d", slot, (start + 10) % 32);
        end
    endtask

    task automatic test_sync();
        wait_slot(13);
        sync = 1;
        step();
        sync = 0;
        checks++;
        if (slot !== 5'd0 || m1 !== 1'b1 || m2 !== 1'b0) begin
            errors++;
            $display("FAIL sync_realign: slot=%0d m1=%b want 0/1", slot, m1);
        end
        step();
        checks++;
        if (slot !== 5'd1) begin
            errors++;
            $display("FAIL sync_restart: slot=%0d want 1", slot);
        end
    endtask

    task automatic test_capture();
        smp_ready = 1;
        wait_slot(24);
        xleft = 16'sh1234; xright = -16'sd5;
        step();
        checks++;
        if (sample !== 1'b1 || smp_valid !== 1'b1 || smp_left !== 16'sh1234 ||
            smp_right !== 16'shFFFB || overrun !== 1'b0) begin
            errors++;
            $display("FAIL capture: sample=%b valid=%b l=%h r=%h ovr=%b want 1 1 1234 fffb 0",
                     sample, smp_valid, smp_left, smp_right, overrun);
        end
        step();
        checks++;
        if (sample !== 1'b0 || smp_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture_transfer: sample=%b valid=%b want 0 0", sample, smp_valid);
        end
    endtask

    task automatic test_overrun();
        smp_ready = 0; clr_ovr = 0;
        wait_slot(24);
        xleft = 16'sd100; xright = 16'sd1;
        step();
        wait_slot(24);
        xleft = 16'sd200; xright = 16'sd2;
        step();
        checks++;
        if (smp_left !== 16'sd200 || overrun !== 1'b1 || smp_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: l=%0d ovr=%b valid=%b want 200 1 1", smp_left, overrun, smp_valid);
        end
        clr_ovr = 1;
        step();
        clr_ovr = 0;
        checks++;
        if (overrun !== 1'b0 || smp_valid !== 1'b1 || smp_left !== 16'sd200) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b valid=%b l=%0d want 0 1 200", overrun, smp_valid, smp_left);
        end
    endtask

    task automatic test_back_to_back();
        // Valid still held from the overrun test; capture and transfer together.
        wait_slot(24);
        xleft = 16'sd300; xright = -16'sd300; smp_ready = 1;
        step();
        smp_ready = 0;
        checks++;
        if (smp_valid !== 1'b1 || smp_left !== 16'sd300 || smp_right !== -16'sd300 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: valid=%b l=%0d r=%0d ovr=%b want 1 300 -300 0",
                     smp_valid, smp_left, smp_right, overrun);
        end
    endtask

    task automatic test_reset_mid();
        wait_slot(24);
        xleft = 16'sd7; xright = 16'sd8;
        step();                      // overwrite of unread sample: overrun = 1
        wait_slot(20);
        rst_n = 0;
        step();
        checks++;
        if (slot !== 5'd0 || smp_valid !== 1'b0 || overrun !== 1'b0 || sample !== 1'b0 ||
            smp_left !== 16'sd0 || smp_right !== 16'sd0 || m1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: slot=%0d valid=%b ovr=%b l=%h r=%h m1=%b want 0 0 0 0 0 1",
                     slot, smp_valid, overrun, smp_left, smp_right, m1);
        end
        checks++;
        if (m2_8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ofs8: m2_enters=%b want 1", m2_8);
        end
        rst_n = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cen       = ($urandom % 3) != 0;
            sync      = ($urandom % 40) == 0;
            smp_ready = ($urandom % 4) == 0;
            clr_ovr   = ($urandom % 10) == 0;
            rst_n     = ($urandom % 300) != 0;
            xleft     = 16'($urandom);
            xright    = 16'($urandom);
            step();
            checks++;
            if (slot !== 5'(m_s) || ch !== 3'(m_s % 8) || {c2, c1, m2, m1} !== exp_strobes(m_s, 0) ||
                op31 !== (m_s == 31)) begin
                errors++;
                $display("FAIL rand_seq: cyc %0d slot=%0d strobes=%b op31=%b want s=%0d", i, slot,
                         {c2, c1, m2, m1}, op31, m_s);
            end
            checks++;
            if (sample !== m_sample || smp_valid !== m_valid || overrun !== m_ovr ||
                smp_left !== m_left || smp_right !== m_right) begin
                errors++;
                $display("FAIL rand_smp: cyc %0d got s=%b v=%b o=%b l=%h r=%h want %b %b %b %h %h", i,
                         sample, smp_valid, overrun, smp_left, smp_right,
                         m_sample, m_valid, m_ovr, m_left, m_right);
            end
            checks++;
            if (slot_8 !== 5'(m_s) || {c2_8, c1_8, m2_8, m1_8} !== exp_strobes(m_s, 8) ||
                op31_8 !== (m_s == 23)) begin
                errors++;
                $display("FAIL rand_ofs8: cyc %0d slot=%0d strobes=%b op31=%b want s=%0d", i, slot_8,
                         {c2_8, c1_8, m2_8, m1_8}, op31_8, m_s);
            end
        end
        rst_n = 1;
    endtask

    initial begin
        m_s = 0; m_valid = 0; m_sample = 0; m_ovr = 0; m_left = 0; m_right = 0;
        rst_n = 0; cen = 0; sync = 0; smp_ready = 0; clr_ovr = 0; xleft = 0; xright = 0;
        #1;
        test_reset();
        test_free_run();
        test_cen_gated();
        test_sync();
        test_capture();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt51_acc_seq.md
JT51_ACC_SEQ -- requirements
Module: jt51_acc_seq

Interface
REQ-001 SHALL have parameter SLOT_OFS, default 0: slot offset 0..31 added mod 32 before strobe decode, to compensate operator pipeline delay.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port cen, input, 1: clock enable; slot sequencing advances only when high.
REQ-005 SHALL have port sync, input, 1: realign request; forces the slot counter to 0 on the next cen.
REQ-006 SHALL have ports xleft, xright, input, 16 signed each: accumulated frame sums from the accumulator.
REQ-007 SHALL have ports m1_enters, m2_enters, c1_enters, c2_enters, op31_acc, output, 1 each: accumulator sequencing strobes.
REQ-008 SHALL have ports slot (output, 5) and ch (output, 3): current slot counter value, and ch = slot[2:0].
REQ-009 SHALL have port sample, output, 1: one-clk pulse on each frame capture.
REQ-010 SHALL have ports smp_valid (output, 1), smp_ready (input, 1), smp_left and smp_right (output, 16 signed each): sample handshake to the consumer.
REQ-011 SHALL have ports overrun (output, 1, sticky) and clr_ovr (input, 1).

Function
REQ-012 SHALL hold a 5-bit slot register s; on a posedge with cen=1: s <= 0 if sync, else s+1 with 31 -> 0 wrap; cen=0 leaves s unchanged and ignores sync.
REQ-013 SHALL define d = (s + SLOT_OFS) mod 32, decoded combinationally from registered s (zero latency from s to strobes).
REQ-014 SHALL drive m1_enters = (d[4:3]==0), m2_enters = (d[4:3]==1), c1_enters = (d[4:3]==2) and c2_enters = (d[4:3]==3), exactly one high at any time.
REQ-015 SHALL drive op31_acc = (d==31) only.
REQ-016 SHALL capture at a posedge where cen=1 and d==24 (first C2 slot, C1 update complete): smp_left <= xleft, smp_right <= xright, smp_valid <= 1, sample pulses high for the following clk.
REQ-017 SHALL complete a transfer on any posedge with smp_valid && smp_ready, independent of cen; smp_valid then clears unless a capture occurs on the same edge.
REQ-018 SHALL treat capture and transfer on the same edge as: the old sample is consumed, the new sample is loaded, smp_valid stays 1, and overrun is not set.
REQ-019 SHALL, on capture while smp_valid=1 and no transfer on that edge, overwrite the held sample (newest wins) and set overrun.
REQ-020 SHALL clear overrun on clr_ovr; a simultaneous set wins.
REQ-021 SHALL keep smp_left and smp_right stable while smp_valid=1 except on an overwrite per REQ-019.
REQ-022 SHALL perform no arithmetic on sample data; values pass bit-exact.

Reset
REQ-023 SHALL, on posedge with rst_n=0 (overriding cen, sync, capture and handshake), set s=0, smp_valid=0, sample=0, overrun=0, smp_left=0 and smp_right=0.
REQ-024 SHALL present strobes decoded from s=0 while in reset (SLOT_OFS=0 gives m1_enters=1 and the rest 0).
REQ-025 SHALL start the first frame on the first cen after rst_n rises, with s: 0 -> 1.

Verification
REQ-026 SHALL be checked with reset, cen=1 continuous, SLOT_OFS=0, over 64 clks -> m1 high for s 0-7, m2 for 8-15, c1 for 16-23, c2 for 24-31; op31_acc only at s=31; s wraps 31 -> 0; ch = s[2:0].
REQ-027 SHALL be checked with cen high 1 in 4 clks -> s advances once per 4 clks; strobes are held between cen pulses; sync asserted with cen=0 has no effect.
REQ-028 SHALL be checked with sync asserted with cen at s=13 -> s=0 next, m1_enters=1; the frame restarts cleanly.
REQ-029 SHALL be checked with smp_ready=1, xleft=16'sh1234, xright=-5 at capture -> sample pulses, smp_valid high for one clk, smp_left=16'h1234, smp_right=16'hFFFB, overrun=0.
REQ-030 SHALL be checked with smp_ready=0 over two captures (xleft 100 then 200) -> smp_left=200, overrun=1; clr_ovr pulse -> overrun=0 with smp_valid still 1.
REQ-031 SHALL be checked with rst_n=0 asserted at s=20 with smp_valid=1 -> next clk s=0, smp_valid=0, overrun=0, outputs zero; SLOT_OFS=8 run -> m2_enters high at s=0.
